wavelet_readout: RTL

WAVELET_READOUT -- requirements
Module: wavelet_readout

---
 rtl/wavelet_pkg.sv | 14 +
 rtl/wavelet_readout.sv | 129 ++++++++++++
 2 files changed

// File: rtl/wavelet_pkg.sv
// Shared constants and state encoding for the wavelet filter-sum byte readout.
package wavelet_pkg;

  localparam int SUM_BITS = 32;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_CSUM
  } rd_state_t;

endpackage

// File: rtl/wavelet_readout.sv
// Serialises a snapshot of packed filter sums into a framed byte stream:
// sync byte, data bytes (filter 0 first, MSB byte first), XOR checksum.
module wavelet_readout #(
  parameter int TOTAL_FILTERS = 3,
  parameter int SUM_BITS      = wavelet_pkg::SUM_BITS
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [TOTAL_FILTERS*SUM_BITS-1:0] i_sum,
  input  logic                              i_sum_valid,
  output logic [7:0]                        o_byte,
  output logic                              o_byte_valid,
  input  logic                              i_byte_ready,
  output logic                              o_frame_start,
  output logic                              o_busy,
  output logic                              o_overrun
);
  import wavelet_pkg::*;

  localparam int BPF    = SUM_BITS / 8;
  localparam int NBYTES = TOTAL_FILTERS * BPF;
  localparam int SNAP_W = TOTAL_FILTERS * SUM_BITS;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  // Reorders the packed sums so stream byte i sits at bits [8*i +: 8]:
  // byte 0 is the MSB byte of filter 0, byte NBYTES-1 the LSB byte of the last filter.
  function automatic logic [SNAP_W-1:0] to_stream(input logic [SNAP_W-1:0] sums);
    logic [SNAP_W-1:0] s;
    s = '0;
    for (int k = 0; k < TOTAL_FILTERS; k++) begin
      for (int b = 0; b < BPF; b++) begin
        s[8*(k*BPF + b) +: 8] = sums[SUM_BITS*k + 8*(BPF-1-b) +: 8];
      end
    end
    return s;
  endfunction

  rd_state_t         state, state_nxt;
  logic [SNAP_W-1:0] snap;
  logic [IDX_W-1:0]  idx;
  logic [7:0]        csum;
  logic              overrun;
  logic              hs;
  logic              capture;
  logic              drop;
  logic [7:0]        data_byte;

  assign data_byte = snap[{idx, 3'b000} +: 8];

  always_comb begin
    state_nxt = state;
    hs        = 1'b0;
    capture   = 1'b0;
    drop      = 1'b0;
    o_byte    = 8'h00;
    case (state)
      ST_IDLE: begin
        if (i_sum_valid) begin
          capture   = 1'b1;
          state_nxt = ST_SYNC;
        end
      end
      ST_SYNC: begin
        o_byte = SYNC_BYTE;
        hs     = i_byte_ready;
        drop   = i_sum_valid;
        if (hs) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        o_byte = data_byte;
        hs     = i_byte_ready;
        drop   = i_sum_valid;
        if (hs && idx == LAST_IDX) state_nxt = ST_CSUM;
      end
      ST_CSUM: begin
        o_byte = csum;
        hs     = i_byte_ready;
        // A new set arriving exactly as the checksum leaves starts the next frame back to back.
        if (hs) begin
          if (i_sum_valid) begin
            capture   = 1'b1;
            state_nxt = ST_SYNC;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          drop = i_sum_valid;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      csum    <= 8'h00;
      overrun <= 1'b0;
    end else begin
      if (drop) overrun <= 1'b1;
      if (capture) begin
        idx  <= '0;
        csum <= 8'h00;
      end else if (hs && state == ST_SYNC) begin
        idx <= '0;
      end else if (hs && state == ST_DATA) begin
        csum <= csum ^ data_byte;
        if (idx != LAST_IDX) idx <= idx + 1'b1;
      end
    end
  end

  // Snapshot is pure data; only the control above needs reset.
  always_ff @(posedge clk) begin
    if (capture) snap <= to_stream(i_sum);
  end

  assign o_byte_valid  = (state != ST_IDLE);
  assign o_busy        = (state != ST_IDLE);
  assign o_frame_start = (state == ST_SYNC);
  assign o_overrun     = overrun;

endmodule
